mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage. Serialises each 1/2/4-byte access into byte beats and assembles read data. Returns a one-cycle acknowledge per access. Drives the `if_stall`/`mem_stall` inputs of the pipeline stall controller. Sits between the IF/MEM stages and the top-level RAM interface.

## Interface
- `ADDR_W`, 32, address width of all address ports.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready; low freezes all state.
- `if_req` in 1: fetch request, held until `if_ack` or abandoned.
- `if_addr` in ADDR_W: fetch address; always a 4-byte read.
- `if_ack` out 1: one-cycle pulse; `if_data` valid.
- `if_data` out 32: fetched word, little-endian.
- `mem_req` in 1: load/store request, held until `mem_ack`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in ADDR_W: data address.
- `mem_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `mem_wdata` in 32: store data; the low `size` bytes are used.
- `mem_ack` out 1: one-cycle pulse; access complete.
- `mem_rdata` out 32: load data, zero-extended. The MEM stage sign-extends.
- `ram_din` in 8: RAM read byte, valid the cycle after its address.
- `ram_dout` out 8: RAM write byte.
- `ram_a` out ADDR_W: RAM byte address.
- `ram_wr` out 1: RAM write enable.
- `if_stall` out 1: `if_req & ~if_ack` (combinational).
- `mem_stall` out 1: `mem_req & ~mem_ack` (combinational).

## Operation
- States:
  - IDLE
  - RD: byte reads
  - WR: byte writes
  - DONE: ack cycle
- Registers: `owner` (IF/MEM), `base`, `n` (1/2/4 bytes), `cnt` (0..4), byte buffer.
- IDLE with `mem_req`=1 grants MEM, whether or not `if_req` is set. MEM has fixed priority; it holds the older instruction.
- IDLE with only `if_req` grants IF.
- On a grant: latch base, size, wdata and we; set `cnt`=0; go to RD or WR.
- WR, each cycle:
  - `ram_a` = `base`+`cnt` (mod 2^ADDR_W).
  - `ram_wr`=1.
  - `ram_dout` = byte `cnt` of wdata.
  - `cnt`++.
  - When `cnt`=`n`-1, next state is DONE.
- RD, each cycle:
  - While `cnt`<`n`: `ram_a` = `base`+`cnt`.
  - When `cnt`>=1: capture `ram_din` into byte `cnt`-1.
  - When `cnt`=`n`: this is the final capture-only cycle; next state is DONE.
- DONE:
  - Raises `owner`'s ack.
  - Read data is presented on `if_data` or `mem_rdata`; bytes >= `n` are 0.
  - Next state is IDLE.
  - Requests are ignored in DONE.
  - The requester deasserts req no later than the IDLE cycle that follows.
- IF abort: if `if_req` drops while the owner is IF in RD, go to IDLE next cycle with no ack. Reads have no side effects.
- MEM accesses are never aborted. Stores always complete.
- Address wrap: `base`+`cnt` wraps mod 2^ADDR_W with no error.
- `rdy`=0:
  - State, `cnt`, buffer and acks hold.
  - `ram_wr` is forced to 0.
  - `ram_din` is not sampled.
  - The RAM holds its output during `rdy`=0.
- Outside WR, `ram_wr`=0. `ram_a` holds its last value in IDLE/DONE.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `if_ack`, `mem_ack`, `ram_wr` all 0.
  - `ram_a`, `ram_dout`, `if_data`, `mem_rdata` all 0.
- Latency is measured from request sampled in IDLE at cycle T, to the ack cycle:
  - read of `n` bytes: T+`n`+2. Word fetch is T+6; byte load is T+3.
  - write of `n` bytes: T+`n`+1. Word store is T+5; byte store is T+2.
- Back-to-back: after ack at A, the earliest next grant is at A+1 (IDLE), with the first beat at A+2.
- Reset asserted mid-access: return to IDLE next cycle, no ack. A partial store is left in RAM as written.
- `rdy` low for k cycles extends latency by exactly k.

## Test plan
- Reset then idle: all outputs 0, `ram_wr` never 1, `if_stall`=`mem_stall`=0.
- IF word fetch:
  - Stimulus: RAM[0x100..0x103] = 11 22 33 44; `if_req` with `if_addr`=0x100 at T.
  - Required response: `ram_a` = 0x100..0x103 at T+1..T+4; `if_ack` at T+6 with `if_data`=0x44332211; `if_stall`=1 for T..T+5.
- Simultaneous requests:
  - Stimulus: `mem_req` store word 0xDEADBEEF @0x200 and `if_req` @0x0 at T.
  - Required response: MEM granted first; `mem_ack` at T+5; RAM[0x200..0x203] = EF BE AD DE; IF granted at T+6; `if_ack` at T+12.
- Byte and half loads:
  - Stimulus: RAM[0x300]=0x80, RAM[0x301]=0x7F.
  - Required response: size 00 load gives `mem_rdata`=0x00000080 at T+3; size 01 load gives 0x00007F80 at T+4.
- IF abort:
  - Stimulus: drop `if_req` at T+2 of a fetch.
  - Required response: no `if_ack`; IDLE at T+3; a `mem_req` issued at T+3 is granted at T+3 and acked normally.
- `rdy` stall:
  - Stimulus: `rdy`=0 for 3 cycles during a word store at beat 2.
  - Required response: `ram_wr`=0 during those cycles; no beat repeated or skipped; `mem_ack` at T+8.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between IF and MEM, serialising accesses into byte beats.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              if_stall,
  output logic              mem_stall
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_nx;
  logic owner_mem;
  logic [ADDR_W-1:0] base, a_last;
  logic [2:0] n, cnt;
  logic [1:0] rb;
  logic [31:0] wdata, rbuf;
  logic drive;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = mem_req ? (mem_we ? WR : RD) : if_req ? RD : IDLE;
      RD: state_nx = (!owner_mem && !if_req) ? IDLE : (cnt == n) ? DONE : RD;
      WR: state_nx = (cnt == n - 3'd1) ? DONE : WR;
      default: state_nx = IDLE;
    endcase
  end
  // RD's last cycle only captures, so the address bus keeps its previous value there
  assign drive = state == WR || (state == RD && cnt < n);
  assign ram_a = drive ? base + ADDR_W'(cnt) : a_last;
  assign ram_wr = state == WR && rdy;
  assign ram_dout = state == WR ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
  assign if_ack = state == DONE && !owner_mem;
  assign mem_ack = state == DONE && owner_mem;
  assign if_data = if_ack ? rbuf : 32'h0;
  assign mem_rdata = mem_ack ? rbuf : 32'h0;
  assign if_stall = if_req && !if_ack;
  assign mem_stall = mem_req && !mem_ack;
  assign rb = 2'(cnt - 3'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      owner_mem <= 1'b0;
      base <= '0;
      a_last <= '0;
      wdata <= '0;
      rbuf <= '0;
    end else if (rdy) begin
      state <= state_nx;
      a_last <= ram_a;
      if (state == IDLE) begin
        cnt <= '0;
        rbuf <= '0;
        owner_mem <= mem_req;
        base <= mem_req ? mem_addr : if_addr;
        n <= (!mem_req || mem_size[1]) ? 3'd4 : mem_size[0] ? 3'd2 : 3'd1;
        wdata <= mem_wdata;
      end else if (state != DONE) begin
        cnt <= cnt + 3'd1;
        if (state == RD && cnt != 3'd0) rbuf[{rb, 3'b000} +: 8] <= ram_din;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural byte RAM.
module tb_mem_arbiter;
  logic clk = 0, rst = 1, rdy = 1;
  logic if_req = 0, mem_req = 0, mem_we = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
  logic [1:0] mem_size = 0;
  logic [7:0] ram_din = 0;
  logic if_ack, mem_ack, ram_wr, if_stall, mem_stall;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic [7:0] ram_dout;
  int vectors = 0, miscompares = 0, cyc = 0, wcnt = 0, w0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .if_stall(if_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:1023];
  logic clr = 0, pl_en = 0;
  logic [9:0] pl_a = 0;
  logic [7:0] pl_d = 0;
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    else if (pl_en) ram[pl_a] <= pl_d;
    else if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    if (rdy) ram_din <= ram[ram_a[9:0]];
    if (ram_wr) wcnt <= wcnt + 1;
  end

  typedef struct {bit m; bit chk; logic [31:0] d; int c;} exp_t;
  exp_t sbq[$];
  exp_t e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst && (if_ack || mem_ack)) begin
    if (sbq.size() == 0) check("spurious_ack", {62'd0, if_ack, mem_ack}, 64'd0);
    else begin
      e = sbq.pop_front();
      check("ack_port", {62'd0, if_ack, mem_ack}, e.m ? 64'd1 : 64'd2);
      check("ack_cycle", 64'(cyc), 64'(e.c));
      if (e.chk) check("ack_data", e.m ? mem_rdata : if_data, e.d);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pl_a = a; pl_d = d; pl_en = 1;
    tick;
    pl_en = 0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    if_addr = a; if_req = 1;
    sbq.push_back('{1'b0, 1'b1, d, cyc + 6});
  endtask

  task automatic mem_op(input bit we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] d, input int lat);
    mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd; mem_req = 1;
    sbq.push_back('{1'b1, !we, d, cyc + lat});
  endtask

  task automatic wait_ack(input bit m);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = m ? mem_ack : if_ack;
    end
    check(m ? "mem_ack_seen" : "if_ack_seen", {63'd0, got}, 64'd1);
    tick;
    if (m) mem_req = 0; else if_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr = 1;
    repeat (3) tick;
    clr = 0; rst = 0;
    @(negedge clk);
    check("rst_if_ack", {63'd0, if_ack}, 64'd0);
    check("rst_mem_ack", {63'd0, mem_ack}, 64'd0);
    check("rst_ram_wr", {63'd0, ram_wr}, 64'd0);
    check("rst_ram_a", 64'(ram_a), 64'd0);
    check("rst_ram_dout", 64'(ram_dout), 64'd0);
    check("rst_if_data", 64'(if_data), 64'd0);
    check("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    check("rst_stalls", {62'd0, if_stall, mem_stall}, 64'd0);
    repeat (3) tick;
    check("idle_no_writes", 64'(wcnt), 64'd0);
    poke(10'h100, 8'h11); poke(10'h101, 8'h22); poke(10'h102, 8'h33); poke(10'h103, 8'h44);
    poke(10'h000, 8'h01); poke(10'h001, 8'h02); poke(10'h002, 8'h03); poke(10'h003, 8'h04);
    poke(10'h300, 8'h80); poke(10'h301, 8'h7F); poke(10'h3FF, 8'hA5);
    // word fetch with address sequence
    fetch(32'h100, 32'h44332211);
    @(negedge clk);
    check("if_stall_T", {63'd0, if_stall}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fetch_ram_a", 64'(ram_a), 64'(32'h100 + i));
    end
    wait_ack(0);
    // simultaneous store + fetch: MEM first, IF granted right after
    mem_op(1, 2'b10, 32'h200, 32'hDEADBEEF, 32'h0, 5);
    fetch(32'h0, 32'h04030201);
    sbq[1].c = cyc + 12;
    wait_ack(1);
    wait_ack(0);
    check("store_word", {32'd0, ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]}, 64'hDEADBEEF);
    mem_op(0, 2'b00, 32'h300, 32'h0, 32'h00000080, 3);
    wait_ack(1);
    mem_op(0, 2'b01, 32'h300, 32'h0, 32'h00007F80, 4);
    wait_ack(1);
    mem_op(0, 2'b11, 32'h100, 32'h0, 32'h44332211, 6);
    wait_ack(1);
    // IF abort at T+2, MEM load granted at T+3
    if_addr = 32'h100; if_req = 1;
    tick; tick;
    if_req = 0;
    tick;
    mem_op(0, 2'b10, 32'h300, 32'h0, 32'h00007F80, 6);
    wait_ack(1);
    // rdy low for three cycles during a word store
    w0 = wcnt;
    mem_op(1, 2'b10, 32'h210, 32'h55AA1234, 32'h0, 8);
    tick; tick;
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rdy_low_no_wr", {63'd0, ram_wr}, 64'd0);
      tick;
    end
    rdy = 1;
    wait_ack(1);
    check("rdy_beats", 64'(wcnt - w0), 64'd4);
    check("rdy_store", {32'd0, ram[10'h213], ram[10'h212], ram[10'h211], ram[10'h210]}, 64'h55AA1234);
    // address wrap
    mem_op(0, 2'b01, 32'hFFFFFFFF, 32'h0, 32'h000001A5, 4);
    tick;
    @(negedge clk);
    check("wrap_a0", 64'(ram_a), 64'hFFFFFFFF);
    tick;
    @(negedge clk);
    check("wrap_a1", 64'(ram_a), 64'd0);
    wait_ack(1);
    // reset mid-store leaves the first two beats
    mem_we = 1; mem_size = 2'b10; mem_addr = 32'h220; mem_wdata = 32'hCAFEF00D; mem_req = 1;
    tick; tick;
    rst = 1; mem_req = 0;
    tick;
    rst = 0;
    repeat (4) tick;
    check("rst_partial", {40'd0, ram[10'h222], ram[10'h221], ram[10'h220]}, 64'h00F00D);
    check("rst_no_ack", {62'd0, if_ack, mem_ack}, 64'd0);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
